// File: rtl/ga_input_vec_builder.sv
// ga_input_vec_builder
// Buffers scalar samples x(n) in a small FIFO and shifts them into an M-tap
// delay line. Each SHIFT presents a new masked regressor vector v(n) to the GA
// main FSM, followed by a one-cycle valid strobe and one mandatory gap cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | wait for a queued sample and the GA ready level
// SHIFT | pop FIFO head into tap 0, shift delay line, latch output
// PULSE | o_valid_pls high for exactly this cycle
// GAP   | one idle cycle so the main FSM's registered ready can drop
module ga_input_vec_builder #(
    parameter int DATA_W      = 16,
    parameter int M_MAX       = 8,
    parameter int M_IDX_MAX_W = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int SIM_DLY     = 1,
    localparam int CHROM_MAX_W = DATA_W * M_MAX,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_ga_enable,
    input  logic [M_IDX_MAX_W-1:0] cnfg_m,
    input  logic                   i_x_valid_pls,
    input  logic [DATA_W-1:0]      i_x_n,
    input  logic                   i_ga_ready,
    output logic                   o_valid_pls,
    output logic [CHROM_MAX_W-1:0] o_v_vec_flat_n,
    output logic [CNT_W-1:0]       o_fifo_count,
    output logic                   o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // SIM_DLY is kept for parameter compatibility with older netlists; the
    // registers here are zero-delay. The empty block only flags bad values.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SIM_DLY < 0) begin : g_bad_params
    end

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [DATA_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   overflow;
    logic [CHROM_MAX_W-1:0] tap_line;
    logic [CHROM_MAX_W-1:0] tap_line_nxt;
    logic [CHROM_MAX_W-1:0] tap_mask;
    logic [CHROM_MAX_W-1:0] vec_out;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = (state == S_SHIFT);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push       = i_x_valid_pls && (!fifo_full || pop);
    assign drop       = i_x_valid_pls && fifo_full && !pop;

    assign tap_line_nxt = {tap_line[CHROM_MAX_W-DATA_W-1:0], fifo_mem[rd_ptr]};

    // Enable mask: taps above cnfg_m read as zero on the output only.
    always_comb begin
        tap_mask = '0;
        for (int k = 0; k < M_MAX; k++) begin
            if (k <= int'(cnfg_m)) begin
                tap_mask[DATA_W*k +: DATA_W] = {DATA_W{1'b1}};
            end
        end
    end

    // Sequencer next-state; ready is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty && i_ga_ready) state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = S_PULSE;
            S_PULSE: state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (i_ga_enable && push) begin
            fifo_mem[wr_ptr] <= i_x_n;
        end
    end

    // Control state, FIFO pointers, delay line and output vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tap_line <= '0;
            vec_out  <= '0;
        end else if (!i_ga_enable) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tap_line <= '0;
            vec_out  <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                tap_line <= tap_line_nxt;
                vec_out  <= tap_line_nxt & tap_mask;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign o_valid_pls    = (state == S_PULSE);
    assign o_v_vec_flat_n = vec_out;
    assign o_fifo_count   = count;
    assign o_overflow     = overflow;

endmodule

// File: tb/tb_ga_input_vec_builder.sv
// Testbench for ga_input_vec_builder: scoreboard of expected vectors, checked
// by a pulse monitor, plus per-scenario inline checks.
module tb_ga_input_vec_builder;

    localparam int DATA_W = 16;
    localparam int M_MAX  = 8;
    localparam int VW     = DATA_W * M_MAX;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ga_enable;
    logic [2:0]    cnfg_m;
    logic          i_x_valid_pls;
    logic [15:0]   i_x_n;
    logic          i_ga_ready;
    logic          o_valid_pls;
    logic [VW-1:0] o_v_vec_flat_n;
    logic [2:0]    o_fifo_count;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int cyc = 0;
    int cur_m = 7;
    logic [VW-1:0] exp_q [$];
    int            pulse_cyc [$];
    logic [15:0]   hist [$];
    logic [VW-1:0] mon_exp;

    ga_input_vec_builder dut (
        .clk            (clk),
        .rst            (rst),
        .i_ga_enable    (i_ga_enable),
        .cnfg_m         (cnfg_m),
        .i_x_valid_pls  (i_x_valid_pls),
        .i_x_n          (i_x_n),
        .i_ga_ready     (i_ga_ready),
        .o_valid_pls    (o_valid_pls),
        .o_v_vec_flat_n (o_v_vec_flat_n),
        .o_fifo_count   (o_fifo_count),
        .o_overflow     (o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every pulse must match the oldest outstanding expected vector.
    always @(negedge clk) begin
        if (!rst && o_valid_pls) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got pulse with vec=%h, required no pulse", o_v_vec_flat_n);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_v_vec_flat_n !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_vec: got %h, required %h", o_v_vec_flat_n, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < M_MAX; k++) begin
            if (k <= cur_m && k < hist.size()) v[DATA_W*k +: DATA_W] = hist[k];
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] v, input bit accept);
        i_x_valid_pls = 1'b1;
        i_x_n         = v;
        if (accept) begin
            hist.push_front(v);
            if (hist.size() > M_MAX) void'(hist.pop_back());
            exp_q.push_back(model_vec());
        end
        step();
        i_x_valid_pls = 1'b0;
    endtask

    task automatic soft_clear(input int m);
        i_ga_enable = 1'b0;
        cnfg_m      = 3'(m);
        cur_m       = m;
        step();
        hist.delete();
        exp_q.delete();
        i_ga_enable = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending vectors, required 0", exp_q.size());
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; i_ga_enable = 1'b0; i_ga_ready = 1'b0;
        i_x_valid_pls = 1'b0; i_x_n = '0; cnfg_m = 3'd7;
        #2;
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", o_valid_pls); end
        checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", o_fifo_count); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", o_overflow); end
        checks++; if (o_v_vec_flat_n !== '0) begin errors++; $display("FAIL rst_vec: got %h, required 0", o_v_vec_flat_n); end
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_latency();
        soft_clear(7);
        i_ga_ready = 1'b1;
        push_sample(16'h0005, 1'b1);
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL lat_t1: got %b, required 0", o_valid_pls); end
        step();
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL lat_t2: got %b, required 0", o_valid_pls); end
        step();
        checks++; if (o_valid_pls !== 1'b1) begin errors++; $display("FAIL lat_t3: got %b, required 1", o_valid_pls); end
        checks++; if (o_v_vec_flat_n !== VW'(16'h0005)) begin errors++; $display("FAIL lat_vec: got %h, required %h", o_v_vec_flat_n, VW'(16'h0005)); end
        step();
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL lat_t4: got %b, required 0", o_valid_pls); end
        repeat (3) step();
    endtask

    task automatic test_tap_order();
        logic [VW-1:0] want;
        int pc;
        soft_clear(3);
        i_ga_ready = 1'b1;
        pc = pulse_cnt;
        for (int i = 1; i <= 5; i++) begin
            push_sample(16'(i), 1'b1);
            repeat (5) step();
        end
        want = {64'h0, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        checks++; if (o_v_vec_flat_n !== want) begin errors++; $display("FAIL tap_order: got %h, required %h", o_v_vec_flat_n, want); end
        checks++; if (pulse_cnt - pc !== 5) begin errors++; $display("FAIL tap_pulses: got %0d, required 5", pulse_cnt - pc); end
        repeat (3) step();
        checks++; if (o_v_vec_flat_n !== want) begin errors++; $display("FAIL tap_hold: got %h, required %h", o_v_vec_flat_n, want); end
        soft_clear(7);
        checks++; if (o_v_vec_flat_n !== '0) begin errors++; $display("FAIL clear_vec: got %h, required 0", o_v_vec_flat_n); end
    endtask

    task automatic test_overflow();
        soft_clear(7);
        i_ga_ready = 1'b0;
        push_sample(16'h000A, 1'b1);
        push_sample(16'h000B, 1'b1);
        push_sample(16'h000C, 1'b1);
        push_sample(16'h000D, 1'b1);
        push_sample(16'h000E, 1'b0);
        checks++; if (o_fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d, required 4", o_fifo_count); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", o_overflow); end
        pulse_cyc.delete();
        i_ga_ready = 1'b1;
        wait_drain(40);
        checks++; if (pulse_cyc.size() !== 4) begin errors++; $display("FAIL ovf_npulse: got %0d, required 4", pulse_cyc.size()); end
        for (int i = 1; i < 4 && i < pulse_cyc.size(); i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] !== 4) begin
                errors++; $display("FAIL ovf_spacing: got %0d, required 4", pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", o_overflow); end
        checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %0d, required 0", o_fifo_count); end
    endtask

    task automatic test_push_pop_full();
        soft_clear(7);
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ppf_clear_ovf: got %b, required 0", o_overflow); end
        i_ga_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_sample(16'h0011 + 16'(i), 1'b1);
        checks++; if (o_fifo_count !== 3'd4) begin errors++; $display("FAIL ppf_full: got %0d, required 4", o_fifo_count); end
        i_ga_ready = 1'b1;
        step();
        push_sample(16'h0015, 1'b1);
        checks++; if (o_fifo_count !== 3'd4) begin errors++; $display("FAIL ppf_count: got %0d, required 4", o_fifo_count); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ppf_ovf: got %b, required 0", o_overflow); end
        wait_drain(60);
        checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL ppf_drained: got %0d, required 0", o_fifo_count); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ppf_ovf_end: got %b, required 0", o_overflow); end
    endtask

    task automatic test_soft_clear();
        int n;
        int pc;
        soft_clear(7);
        i_ga_ready = 1'b0;
        push_sample(16'h0021, 1'b1);
        push_sample(16'h0022, 1'b1);
        push_sample(16'h0023, 1'b1);
        i_ga_ready = 1'b1;
        n = 0;
        while (o_valid_pls !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (o_valid_pls !== 1'b1) begin errors++; $display("FAIL sc_reach_pulse: got %b, required 1", o_valid_pls); end
        checks++; if (o_fifo_count !== 3'd2) begin errors++; $display("FAIL sc_queued: got %0d, required 2", o_fifo_count); end
        i_ga_enable = 1'b0;
        step();
        exp_q.delete();
        hist.delete();
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL sc_valid: got %b, required 0", o_valid_pls); end
        checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL sc_count: got %0d, required 0", o_fifo_count); end
        checks++; if (o_v_vec_flat_n !== '0) begin errors++; $display("FAIL sc_vec: got %h, required 0", o_v_vec_flat_n); end
        i_ga_enable = 1'b1;
        pc = pulse_cnt;
        repeat (8) step();
        checks++; if (pulse_cnt !== pc) begin errors++; $display("FAIL sc_no_pulse: got %0d pulses, required 0", pulse_cnt - pc); end
        push_sample(16'h0007, 1'b1);
        step();
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL sc_lat_t2: got %b, required 0", o_valid_pls); end
        step();
        checks++; if (o_valid_pls !== 1'b1) begin errors++; $display("FAIL sc_lat_t3: got %b, required 1", o_valid_pls); end
        checks++; if (o_v_vec_flat_n !== VW'(16'h0007)) begin errors++; $display("FAIL sc_tap0: got %h, required %h", o_v_vec_flat_n, VW'(16'h0007)); end
        repeat (4) step();
    endtask

    task automatic test_reset_midrun();
        i_ga_ready = 1'b0;
        push_sample(16'h0031, 1'b0);
        push_sample(16'h0032, 1'b0);
        checks++; if (o_fifo_count !== 3'd2) begin errors++; $display("FAIL mr_pre_count: got %0d, required 2", o_fifo_count); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (o_valid_pls !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b, required 0", o_valid_pls); end
        checks++; if (o_fifo_count !== 3'd0) begin errors++; $display("FAIL mr_count: got %0d, required 0", o_fifo_count); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL mr_overflow: got %b, required 0", o_overflow); end
        checks++; if (o_v_vec_flat_n !== '0) begin errors++; $display("FAIL mr_vec: got %h, required 0", o_v_vec_flat_n); end
        step();
        rst = 1'b0;
        exp_q.delete();
        hist.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_tap_order();
        test_overflow();
        test_push_pop_full();
        test_soft_clear();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
